// File: rtl/receptor_trama.sv
// Serial frame receiver for the four-slot round-robin link.
// Recovers start/8 data/even parity/stop frames from an oversampled line
// and writes each good byte into the next output slot in rotation.
module receptor_trama #(
    parameter int OVERSAMPLE = 16,
    parameter int SLOTS_LOG2 = 2
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iCE,
    input  logic                  iDato,
    output logic [7:0]            ovDato0,
    output logic [7:0]            ovDato1,
    output logic [7:0]            ovDato2,
    output logic [7:0]            ovDato3,
    output logic [SLOTS_LOG2-1:0] ovIndice,
    output logic                  oValido,
    output logic                  oErrorParidad,
    output logic                  oErrorTrama
);

    localparam int SLOTS = 1 << SLOTS_LOG2;
    localparam int CNT_W = $clog2(OVERSAMPLE);
    // Tick counter restarts at 0 on the tick after a sample, so the
    // compare values are one less than the wanted spacing.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [1:0]            sync_q, sync_d;
    logic                  line;
    logic                  prev_q, prev_d;
    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      tick_q, tick_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_bad_q, stop_bad_d;
    logic                  fin_q, fin_d;
    logic [SLOTS_LOG2-1:0] slot_q, slot_d;
    logic [SLOTS_LOG2-1:0] indice_q, indice_d;
    logic                  valido_q, valido_d;
    logic                  err_par_q, err_par_d;
    logic                  err_trama_q, err_trama_d;
    logic                  write_en;

    assign line = sync_q[1];

    // Two-flop synchronizer for the asynchronous serial line.
    always_comb begin
        sync_d = {sync_q[0], iDato};
    end

    // Frame FSM: start detection, mid-bit sampling, parity and stop capture.
    always_comb begin
        prev_d     = prev_q;
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        stop_bad_d = stop_bad_q;
        fin_d      = 1'b0;
        if (iCE) begin
            prev_d = line;
            case (state_q)
                S_IDLE: begin
                    if (!prev_q && line) begin
                        tick_d  = '0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (tick_q == HALF_M1) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = line ? S_DATA : S_IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_q == FULL_M1) begin
                        tick_d  = '0;
                        shift_d = {line, shift_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tick_q == FULL_M1) begin
                        tick_d    = '0;
                        par_err_d = line ^ (^shift_q);
                        state_d   = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_q == FULL_M1) begin
                        tick_d     = '0;
                        stop_bad_d = line;
                        fin_d      = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Status pulses and slot rotation, one clock after the last stop sample.
    // The slot counter advances even on bad frames to stay aligned with the sender.
    always_comb begin
        slot_d      = slot_q;
        indice_d    = indice_q;
        valido_d    = 1'b0;
        err_par_d   = 1'b0;
        err_trama_d = 1'b0;
        if (fin_q) begin
            indice_d = slot_q;
            slot_d   = slot_q + 1'b1;
            if (stop_bad_q) begin
                err_trama_d = 1'b1;
            end else if (par_err_q) begin
                err_par_d = 1'b1;
            end else begin
                valido_d = 1'b1;
            end
        end
    end

    assign write_en = fin_q && !stop_bad_q && !par_err_q;

    // Receiver state registers.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            sync_q      <= '0;
            prev_q      <= 1'b0;
            state_q     <= S_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            stop_bad_q  <= 1'b0;
            fin_q       <= 1'b0;
            slot_q      <= '0;
            indice_q    <= '0;
            valido_q    <= 1'b0;
            err_par_q   <= 1'b0;
            err_trama_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            stop_bad_q  <= stop_bad_d;
            fin_q       <= fin_d;
            slot_q      <= slot_d;
            indice_q    <= indice_d;
            valido_q    <= valido_d;
            err_par_q   <= err_par_d;
            err_trama_q <= err_trama_d;
        end
    end

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic [7:0] dato_q, dato_d;

        // Load this slot only with a good frame addressed to it.
        always_comb begin
            dato_d = dato_q;
            if (write_en && (slot_q == SLOTS_LOG2'(gi))) begin
                dato_d = shift_q;
            end
        end

        // Slot holding register.
        always_ff @(posedge iClk or posedge iReset) begin
            if (iReset) begin
                dato_q <= 8'h00;
            end else begin
                dato_q <= dato_d;
            end
        end
    end

    assign ovDato0       = g_slot[0].dato_q;
    assign ovDato1       = g_slot[1].dato_q;
    assign ovDato2       = g_slot[2].dato_q;
    assign ovDato3       = g_slot[3].dato_q;
    assign ovIndice      = indice_q;
    assign oValido       = valido_q;
    assign oErrorParidad = err_par_q;
    assign oErrorTrama   = err_trama_q;

endmodule

// File: tb/tb_receptor_trama.sv
// Bench for receptor_trama: directed and random frames against a
// frame-level model (slot rotation, parity rule, expected tick timing).
module tb_receptor_trama;

    localparam int OS = 16;

    logic       iClk = 1'b0;
    logic       iReset;
    logic       iCE;
    logic       iDato;
    logic [7:0] ovDato0, ovDato1, ovDato2, ovDato3;
    logic [1:0] ovIndice;
    logic       oValido, oErrorParidad, oErrorTrama;

    always #5 iClk = ~iClk;

    receptor_trama #(.OVERSAMPLE(OS), .SLOTS_LOG2(2)) dut (
        .iClk          (iClk),
        .iReset        (iReset),
        .iCE           (iCE),
        .iDato         (iDato),
        .ovDato0       (ovDato0),
        .ovDato1       (ovDato1),
        .ovDato2       (ovDato2),
        .ovDato3       (ovDato3),
        .ovIndice      (ovIndice),
        .oValido       (oValido),
        .oErrorParidad (oErrorParidad),
        .oErrorTrama   (oErrorTrama)
    );

    // kind: 1 = valid, 2 = parity error, 4 = framing error (bitwise OR if several)
    typedef struct {
        logic [2:0] kind;
        logic [1:0] idx;
        int         tick;
        int         lat;
    } ev_t;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    logic [7:0] mdl_slot [4];
    int         mdl_ptr;
    int         checks = 0;
    int         errors = 0;
    int         tick_idx = 0;
    int         last_ce = 0;
    int         clk_since = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock; records any status pulse with the last iCE tick index.
    task automatic clk_cycle();
        ev_t e;
        @(posedge iClk);
        if (iCE === 1'b1) begin
            last_ce = tick_idx;
            tick_idx++;
            clk_since = 0;
        end else begin
            clk_since++;
        end
        #1;
        if (oValido || oErrorParidad || oErrorTrama) begin
            e.kind = {oErrorTrama, oErrorParidad, oValido};
            e.idx  = ovIndice;
            e.tick = last_ce;
            e.lat  = clk_since;
            got_q.push_back(e);
            $display("t=%0t pulse kind=%0d idx=%0d tick=%0d", $time, e.kind, e.idx, e.tick);
        end
    endtask

    // One oversampling tick with the line at v; random number of idle clocks.
    task automatic tick(input logic v);
        iDato = v;
        repeat (2 + $urandom_range(0, 2)) clk_cycle();
        iCE = 1'b1;
        clk_cycle();
        iCE = 1'b0;
    endtask

    task automatic ticks(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_hi, input int low_bits);
        int   t0;
        logic p;
        ev_t  e;
        t0 = tick_idx;
        p  = (^d) ^ par_bad;
        ticks(1'b1, OS);
        for (int i = 0; i < 8; i++) ticks(d[i], OS);
        ticks(p, OS);
        ticks(stop_hi, OS);
        if (stop_hi) ticks(1'b1, 3 * OS);
        ticks(1'b0, low_bits * OS);
        e.kind = stop_hi ? 3'd4 : (par_bad ? 3'd2 : 3'd1);
        e.idx  = 2'(mdl_ptr);
        e.tick = t0 + OS / 2 + 10 * OS;
        e.lat  = 1;
        exp_q.push_back(e);
        if (e.kind == 3'd1) mdl_slot[mdl_ptr] = d;
        mdl_ptr = (mdl_ptr + 1) % 4;
        $display("frame data=%02h par_bad=%0d stop_hi=%0d slot=%0d", d, par_bad, stop_hi, e.idx);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, " events"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, " kind"}, got_q[i].kind, exp_q[i].kind);
            chk({tag, " index"}, got_q[i].idx, exp_q[i].idx);
            chk({tag, " tick"}, got_q[i].tick, exp_q[i].tick);
            chk({tag, " clk latency"}, got_q[i].lat, exp_q[i].lat);
        end
        chk({tag, " slot0"}, ovDato0, mdl_slot[0]);
        chk({tag, " slot1"}, ovDato1, mdl_slot[1]);
        chk({tag, " slot2"}, ovDato2, mdl_slot[2]);
        chk({tag, " slot3"}, ovDato3, mdl_slot[3]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " ovDato0"}, ovDato0, 8'h00);
        chk({tag, " ovDato1"}, ovDato1, 8'h00);
        chk({tag, " ovDato2"}, ovDato2, 8'h00);
        chk({tag, " ovDato3"}, ovDato3, 8'h00);
        chk({tag, " ovIndice"}, ovIndice, 2'd0);
        chk({tag, " oValido"}, oValido, 1'b0);
        chk({tag, " oErrorParidad"}, oErrorParidad, 1'b0);
        chk({tag, " oErrorTrama"}, oErrorTrama, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        int         sel;
        iReset = 1'b1;
        iCE    = 1'b0;
        iDato  = 1'b0;
        for (int i = 0; i < 4; i++) mdl_slot[i] = 8'h00;
        mdl_ptr = 0;
        repeat (3) clk_cycle();
        check_zero("reset");
        iReset = 1'b0;
        ticks(1'b0, 2 * OS);

        // Four good frames, then wrap to slot 0
        send_frame(8'hA5, 1'b0, 1'b0, 2); check_frame("A5");
        send_frame(8'h07, 1'b0, 1'b0, 2); check_frame("07");
        send_frame(8'h00, 1'b0, 1'b0, 2); check_frame("00");
        send_frame(8'hFF, 1'b0, 1'b0, 2); check_frame("FF");
        send_frame(8'h3C, 1'b0, 1'b0, 2); check_frame("3C wrap");

        // Parity error, then a good frame in the following slot
        send_frame(8'h07, 1'b1, 1'b0, 2); check_frame("parity err");
        send_frame(8'h5A, 1'b0, 1'b0, 0); check_frame("after parity");

        // Framing error with line held high, then low and a good frame
        send_frame(8'h81, 1'b0, 1'b1, 1); check_frame("frame err");
        send_frame(8'hC3, 1'b0, 1'b0, 2); check_frame("after frame err");

        // Short high glitch on the idle line: no pulse, slot unchanged
        ticks(1'b1, OS / 4);
        ticks(1'b0, 2 * OS);
        check_frame("glitch");
        send_frame(8'h96, 1'b0, 1'b0, 2); check_frame("after glitch");

        // Reset during data bit 4
        d = 8'h6B;
        ticks(1'b1, OS);
        for (int i = 0; i < 4; i++) ticks(d[i], OS);
        ticks(d[4], OS / 2);
        iReset = 1'b1;
        #1;
        check_zero("mid reset");
        iDato = 1'b0;
        repeat (2) clk_cycle();
        iReset = 1'b0;
        chk("mid reset events", got_q.size(), 0);
        got_q.delete();
        for (int i = 0; i < 4; i++) mdl_slot[i] = 8'h00;
        mdl_ptr = 0;
        ticks(1'b0, 2 * OS);
        send_frame(8'h24, 1'b0, 1'b0, 2); check_frame("after reset");

        // Random frames with occasional parity/framing errors
        for (int n = 0; n < 12; n++) begin
            d   = 8'($urandom);
            sel = $urandom_range(0, 5);
            if (sel == 0)      send_frame(d, 1'b1, 1'b0, $urandom_range(0, 2));
            else if (sel == 1) send_frame(d, 1'b0, 1'b1, 1);
            else               send_frame(d, 1'b0, 1'b0, $urandom_range(0, 2));
            check_frame("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
